axis_pkt_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one AXI-Stream sink (the stream FIFO's slave port) among `NUM_SRC` AXI-Stream requesters. It grants one source at a time and holds the grant until that source's packet ends. A packet ends on TLAST or on a `MAX_BEATS` length cap. The grant then rotates fairly. It sits directly in front of the FIFO's slave interface.

---
 rtl/axis_pkt_arbiter.sv | 67 ++++++
 tb/tb_axis_pkt_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: round-robin, packet-locked arbiter sharing one AXI-Stream sink among NUM_SRC sources
module axis_pkt_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          trunc_err
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS);
    typedef enum logic {IDLE, PASS} state_t;
    state_t          r_state, w_next;
    logic [GW-1:0]   r_grant, r_last, w_sel;
    logic [BW-1:0]   r_cnt;
    logic            w_found, w_cap, w_hs;
    assign grant_id = r_grant;
    always_comb begin
        w_sel   = r_grant;
        w_found = 1'b0;
        // rotation search starting just after the last granted source
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!w_found && s_axis_tvalid[(int'(r_last) + k) % NUM_SRC]) begin
                w_sel   = GW'((int'(r_last) + k) % NUM_SRC);
                w_found = 1'b1;
            end
        end
        busy                   = r_state == PASS;
        w_cap                  = r_cnt == BW'(MAX_BEATS - 1);
        m_axis_tvalid          = busy & s_axis_tvalid[r_grant];
        m_axis_tdata           = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast           = busy & (s_axis_tlast[r_grant] | w_cap);
        s_axis_tready          = '0;
        s_axis_tready[r_grant] = busy & m_axis_tready;
        w_hs                   = m_axis_tvalid & m_axis_tready;
        w_next = busy ? ((w_hs & m_axis_tlast) ? IDLE : PASS) : (w_found ? PASS : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_last    <= GW'(NUM_SRC - 1);
            r_cnt     <= '0;
            trunc_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            trunc_err <= w_hs & w_cap & ~s_axis_tlast[r_grant];
            if (!busy && w_found) begin
                r_grant <= w_sel;
                r_cnt   <= '0;
            end
            if (w_hs) r_cnt <= m_axis_tlast ? '0 : r_cnt + 1'b1;
            if (w_hs && m_axis_tlast) r_last <= r_grant;
        end
    end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed and randomized checks against a per-source queue model of the arbiter
module tb_axis_pkt_arbiter;
    localparam int N = 4;
    localparam int MB = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] sv, sl, sr;
    logic [N*32-1:0] sd;
    logic mr, mv, ml, busy, te;
    logic [31:0] md;
    logic [1:0] gid;
    logic [2:0] v3, l3, r3;
    logic [95:0] d3;
    logic mv3, ml3, b3, te3;
    logic [31:0] md3;
    logic [1:0] g3;
    always #5 clk = ~clk;
    axis_pkt_arbiter #(.NUM_SRC(N), .DATA_WIDTH(32), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis_tvalid(sv), .s_axis_tdata(sd), .s_axis_tlast(sl),
        .s_axis_tready(sr), .m_axis_tvalid(mv), .m_axis_tdata(md), .m_axis_tlast(ml),
        .m_axis_tready(mr), .grant_id(gid), .busy(busy), .trunc_err(te));
    axis_pkt_arbiter #(.NUM_SRC(3), .DATA_WIDTH(32), .MAX_BEATS(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_axis_tvalid(v3), .s_axis_tdata(d3), .s_axis_tlast(l3),
        .s_axis_tready(r3), .m_axis_tvalid(mv3), .m_axis_tdata(md3), .m_axis_tlast(ml3),
        .m_axis_tready(1'b1), .grant_id(g3), .busy(b3), .trunc_err(te3));
    logic [32:0] mem [N][512];
    int hd [N], tl [N];
    bit en [N];
    bit mb, mtrunc, pb;
    int mg, mlg, mn, checks, fails, ntrunc;
    int gseq [$];
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic push(int s, int n, logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            mem[s][tl[s]] = {b == n - 1, base + 32'(b)};
            tl[s]++;
        end
    endtask
    function automatic bit pend();
        pend = mb;
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) pend = 1;
    endfunction
    task automatic model_reset();
        mb = 0; mg = 0; mlg = N - 1; mn = 0; mtrunc = 0; pb = 0;
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            sv[i] = (hd[i] < tl[i]) && en[i];
            {sl[i], sd[i*32 +: 32]} = (hd[i] < tl[i]) ? mem[i][hd[i]] : 33'd0;
        end
    endtask
    task automatic step(bit r);
        bit ev, el;
        logic [N-1:0] er;
        mr = r;
        drive();
        #1;
        ev = mb && sv[mg];
        el = mb && (sl[mg] || mn == MB - 1);
        er = mb ? N'(r) << mg : '0;
        chk("m_tvalid", mv, ev);
        chk("m_tlast", ml, el);
        chk("s_tready", sr, er);
        chk("grant_id", gid, mg);
        chk("busy", busy, mb);
        chk("trunc_err", te, mtrunc);
        if (ev) chk("m_tdata", md, mem[mg][hd[mg]][31:0]);
        if (te) ntrunc++;
        if (busy && !pb) gseq.push_back(int'(gid));
        pb = busy;
        @(posedge clk);
        mtrunc = 0;
        if (mb) begin
            if (ev && r) begin
                hd[mg]++;
                if (el) begin
                    mtrunc = !sl[mg];
                    mb = 0; mlg = mg; mn = 0;
                end else mn++;
            end
        end else begin
            for (int k = 1; k <= N; k++)
                if (!mb && sv[(mlg + k) % N]) begin
                    mb = 1; mg = (mlg + k) % N; mn = 0;
                end
        end
        @(negedge clk);
    endtask
    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_lk [3] = '{1, 2, 0};
        bit pat [4] = '{1, 0, 0, 1};
        model_reset();
        v3 = '0; l3 = '0; d3 = '0; mr = 1;
        for (int i = 0; i < N; i++) begin
            en[i] = 1;
            push(i, 3, 32'hA0 + 32'(i * 16));
        end
        push(0, 3, 32'hA3);
        @(negedge clk);
        drive();
        #1;
        chk("rst_s_tready", sr, 0);
        chk("rst_m_tvalid", mv, 0);
        chk("rst_m_tlast", ml, 0);
        chk("rst_grant_id", gid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc_err", te, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (20) step(1);
        chk("rr_count", gseq.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", gseq[i], exp_rr[i]);
        gseq.delete();
        en[0] = 0; en[2] = 0; en[3] = 0;
        push(1, 5, 32'h10);
        push(0, 2, 32'h20);
        push(2, 2, 32'h30);
        repeat (3) step(1);
        en[0] = 1; en[2] = 1;
        repeat (14) step(1);
        chk("lock_count", gseq.size(), 3);
        for (int i = 0; i < 3; i++) chk("lock_order", gseq[i], exp_lk[i]);
        en[3] = 1;
        push(3, 5, 32'h40);
        for (int i = 0; i < 24; i++) step(pat[i % 4]);
        ntrunc = 0;
        push(2, 20, 32'h200);
        repeat (30) step(1);
        chk("trunc_pulses", ntrunc, 1);
        chk("trunc_drained", pend(), 0);
        push(1, 6, 32'h60);
        repeat (3) step(1);
        #2 rst_n = 0;
        #1;
        chk("arst_m_tvalid", mv, 0);
        chk("arst_s_tready", sr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_grant_id", gid, 0);
        chk("arst_m_tlast", ml, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (10) step(1);
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 8; p++) push(s, $urandom_range(1, 6), 32'(s << 12) + 32'(p << 4));
        push(0, 19, 32'h7000);
        for (int c = 0; c < 3000 && pend(); c++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom % 4) != 0;
            step(($urandom % 4) != 0);
        end
        chk("random_drained", pend(), 0);
        v3 = 3'b100; l3 = 3'b100; d3[64 +: 32] = 32'h2;
        #1 chk("wrap_idle", b3, 0);
        @(negedge clk);
        #1;
        chk("wrap_busy2", b3, 1);
        chk("wrap_grant2", g3, 2);
        chk("wrap_ready2", r3, 3'b100);
        chk("wrap_data2", md3, 32'h2);
        @(negedge clk);
        v3 = 3'b001; l3 = 3'b001; d3[0 +: 32] = 32'h5;
        #1;
        chk("wrap_bubble", b3, 0);
        chk("wrap_hold_grant", g3, 2);
        @(negedge clk);
        #1;
        chk("wrap_busy0", b3, 1);
        chk("wrap_grant0", g3, 0);
        chk("wrap_data0", md3, 32'h5);
        chk("wrap_last0", ml3, 1);
        chk("wrap_trunc", te3, 0);
        v3 = '0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
